// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       illegalOp;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/cache bundle: instruction inputs, handshake and control word.
interface mips_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             zero;
  logic             memReady;
  logic [1:0]       aluOp;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [1:0]       pcSrc;
  logic             pcEn;
  logic             iorD;
  logic             memRead;
  logic             memWrite;
  logic             irWrite;
  logic             regDst;
  logic             memToReg;
  logic             regWrite;
  logic             illegalOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, zero, memReady,
    output aluOp, aluSrcA, aluSrcB, pcSrc, pcEn, iorD, memRead, memWrite,
           irWrite, regDst, memToReg, regWrite, illegalOp, state, retired
  );

  modport slave (
    output opcode, zero, memReady,
    input  aluOp, aluSrcA, aluSrcB, pcSrc, pcEn, iorD, memRead, memWrite,
           irWrite, regDst, memToReg, regWrite, illegalOp, state, retired
  );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational state/opcode decoder: control word, next state and retire strobe.
// ADDI states are decoded only when MIPS_CTRL_ADDI_EN is defined.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic       rst_n,
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output ctrl_t      ctrl,
  output state_t     next_state,
  output logic       retire
);

  ctrl_t ctrl_s;

  // Per-state control word and transition; unlisted fields stay zero.
  always_comb begin
    ctrl_s     = '0;
    next_state = S_FETCH;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl_s.memRead = 1'b1;
        ctrl_s.aluSrcB = SRCB_FOUR;
        ctrl_s.aluOp   = ALUOP_ADD;
        ctrl_s.pcSrc   = PCSRC_ALU;
        if (memReady) begin
          ctrl_s.irWrite = 1'b1;
          ctrl_s.pcEn    = 1'b1;
          next_state     = S_DECODE;
        end else begin
          next_state     = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl_s.aluSrcB = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
          OP_ADDI:      next_state = S_ADDIEXEC;
`endif
          default: begin
            ctrl_s.illegalOp = 1'b1;
            next_state       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl_s.aluSrcA = 1'b1;
        ctrl_s.aluSrcB = SRCB_IMM;
        next_state     = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl_s.memRead = 1'b1;
        ctrl_s.iorD    = 1'b1;
        next_state     = memReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl_s.regWrite = 1'b1;
        ctrl_s.memToReg = 1'b1;
        retire          = 1'b1;
      end
      S_MEMWR: begin
        ctrl_s.memWrite = 1'b1;
        ctrl_s.iorD     = 1'b1;
        next_state      = memReady ? S_FETCH : S_MEMWR;
        retire          = memReady;
      end
      S_EXEC: begin
        ctrl_s.aluSrcA = 1'b1;
        ctrl_s.aluSrcB = SRCB_REGB;
        ctrl_s.aluOp   = ALUOP_FUNCT;
        next_state     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_s.regWrite = 1'b1;
        ctrl_s.regDst   = 1'b1;
        retire          = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.aluSrcA = 1'b1;
        ctrl_s.aluOp   = ALUOP_SUB;
        ctrl_s.pcSrc   = PCSRC_ALUOUT;
        ctrl_s.pcEn    = zero;
        retire         = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pcSrc = PCSRC_JUMP;
        ctrl_s.pcEn  = 1'b1;
        retire       = 1'b1;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDIEXEC: begin
        ctrl_s.aluSrcA = 1'b1;
        ctrl_s.aluSrcB = SRCB_IMM;
        next_state     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl_s.regWrite = 1'b1;
        retire          = 1'b1;
      end
`endif
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // Reset must drop cache requests immediately, even mid-stall.
  assign ctrl = rst_n ? ctrl_s : '0;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control: state register and retired-instruction counter.
// Optional ADDI support is enabled by defining MIPS_CTRL_ADDI_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mips_ctrl_if.master bus
);

  state_t           state_r;
  state_t           next_state_s;
  logic             retire_s;
  logic [CNT_W-1:0] retired_r;
  ctrl_t            ctrl_s;

  mips_ctrl_outdec u_outdec (
    .rst_n      (rst_n),
    .state      (state_r),
    .opcode     (bus.opcode),
    .zero       (bus.zero),
    .memReady   (bus.memReady),
    .ctrl       (ctrl_s),
    .next_state (next_state_s),
    .retire     (retire_s)
  );

  // State register and wrapping retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      retired_r <= '0;
    end else begin
      state_r <= next_state_s;
      if (retire_s) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign bus.aluOp     = ctrl_s.aluOp;
  assign bus.aluSrcA   = ctrl_s.aluSrcA;
  assign bus.aluSrcB   = ctrl_s.aluSrcB;
  assign bus.pcSrc     = ctrl_s.pcSrc;
  assign bus.pcEn      = ctrl_s.pcEn;
  assign bus.iorD      = ctrl_s.iorD;
  assign bus.memRead   = ctrl_s.memRead;
  assign bus.memWrite  = ctrl_s.memWrite;
  assign bus.irWrite   = ctrl_s.irWrite;
  assign bus.regDst    = ctrl_s.regDst;
  assign bus.memToReg  = ctrl_s.memToReg;
  assign bus.regWrite  = ctrl_s.regWrite;
  assign bus.illegalOp = ctrl_s.illegalOp;
  assign bus.state     = state_r;
  assign bus.retired   = retired_r;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios plus a random instruction
// stream checked against an instruction-level path model.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;
  localparam int CNT_W  = 32;
  localparam int B_PCEN = 8;
  localparam int B_IRW  = 4;
  localparam int B_ILL  = 0;

  logic             clk;
  logic             rst_n;
  int               errors;
  int               checks;
  logic [CNT_W-1:0] exp_ret;
  int               exp_path[$];
  bit               plan_retire;
  logic [15:0]      tbl [16];

  mips_ctrl_if #(.CNT_W(CNT_W)) bus ();
  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: aluOp, aluSrcA, aluSrcB, pcSrc, pcEn, iorD, memRead, memWrite,
  // irWrite, regDst, memToReg, regWrite, illegalOp.
  function automatic logic [15:0] obs();
    return {bus.aluOp, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.pcEn, bus.iorD,
            bus.memRead, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
            bus.regWrite, bus.illegalOp};
  endfunction

  // Instruction-level model: sequence of states an opcode walks through.
  function automatic void plan(input logic [5:0] op);
    exp_path = {};
    exp_path.push_back(0);
    exp_path.push_back(1);
    plan_retire = 1'b1;
    if (op == OP_LW) begin
      exp_path.push_back(2); exp_path.push_back(3); exp_path.push_back(4);
    end else if (op == OP_SW) begin
      exp_path.push_back(2); exp_path.push_back(5);
    end else if (op == OP_R) begin
      exp_path.push_back(6); exp_path.push_back(7);
    end else if (op == OP_BEQ) begin
      exp_path.push_back(8);
    end else if (op == OP_J) begin
      exp_path.push_back(9);
`ifdef MIPS_CTRL_ADDI_EN
    end else if (op == OP_ADDI) begin
      exp_path.push_back(10); exp_path.push_back(11);
`endif
    end else begin
      plan_retire = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.memReady = 1'b1; bus.opcode = OP_R; bus.zero = 1'b1;
    #1;
    checks++; if (obs() !== 16'h0000) begin errors++; $display("FAIL reset_outputs got=%h want=0000", obs()); end
    checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    checks++; if (bus.retired !== '0) begin errors++; $display("FAIL reset_retired got=%0d want=0", bus.retired); end
    exp_ret = '0;
  endtask

  task automatic test_fetch_stall();
    @(negedge clk);
    rst_n = 1'b1; bus.opcode = OP_J;
    for (int c = 0; c < 4; c++) begin
      bus.memReady = (c == 3);
      #1;
      checks++;
      if (bus.memRead !== 1'b1 || bus.irWrite !== (c == 3) || bus.pcEn !== (c == 3) || bus.state !== 4'd0) begin
        errors++;
        $display("FAIL fetch_stall cyc=%0d got mr=%b ir=%b pe=%b st=%0d want mr=1 ir=%b pe=%b st=0",
                 c, bus.memRead, bus.irWrite, bus.pcEn, bus.state, c == 3, c == 3);
      end
      tick();
    end
    checks++; if (bus.state !== 4'd1) begin errors++; $display("FAIL fetch_to_decode got=%0d want=1", bus.state); end
    tick();
    checks++;
    if (bus.state !== 4'd9 || bus.pcEn !== 1'b1 || bus.pcSrc !== 2'b10) begin
      errors++; $display("FAIL jump_state got st=%0d pe=%b ps=%b want st=9 pe=1 ps=10", bus.state, bus.pcEn, bus.pcSrc);
    end
    tick();
    exp_ret = exp_ret + 1;
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL jump_retired got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  task automatic test_lw();
    int p [5];
    p = '{0, 1, 2, 3, 4};
    bus.opcode = OP_LW; bus.memReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.state !== 4'(p[i])) begin errors++; $display("FAIL lw_path step=%0d got=%0d want=%0d", i, bus.state, p[i]); end
      if (i == 4) begin
        checks++;
        if (bus.regWrite !== 1'b1 || bus.memToReg !== 1'b1 || bus.regDst !== 1'b0) begin
          errors++; $display("FAIL lw_memwb got rw=%b m2r=%b rd=%b want 1 1 0", bus.regWrite, bus.memToReg, bus.regDst);
        end
      end
      tick();
    end
    exp_ret = exp_ret + 1;
    checks++; if (bus.retired !== exp_ret || bus.state !== 4'd0) begin errors++; $display("FAIL lw_retired got=%0d st=%0d want=%0d st=0", bus.retired, bus.state, exp_ret); end
  endtask

  task automatic test_rtype();
    bus.opcode = OP_R; bus.memReady = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus.state !== 4'd6 || bus.aluOp !== 2'b10 || bus.aluSrcA !== 1'b1) begin errors++; $display("FAIL r_exec got st=%0d op=%b want st=6 op=10", bus.state, bus.aluOp); end
    tick();
    checks++; if (bus.state !== 4'd7 || bus.regWrite !== 1'b1 || bus.regDst !== 1'b1) begin errors++; $display("FAIL r_aluwb got st=%0d rw=%b rd=%b want st=7 1 1", bus.state, bus.regWrite, bus.regDst); end
    tick();
    exp_ret = exp_ret + 1;
    checks++; if (bus.state !== 4'd0 || bus.retired !== exp_ret) begin errors++; $display("FAIL r_done got st=%0d ret=%0d want st=0 ret=%0d", bus.state, bus.retired, exp_ret); end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      bus.opcode = OP_BEQ; bus.memReady = 1'b1;
      tick(); tick();
      bus.zero = (t == 0);
      #1;
      checks++;
      if (bus.state !== 4'd8 || bus.pcEn !== (t == 0) || bus.aluOp !== 2'b01 || bus.pcSrc !== 2'b01) begin
        errors++; $display("FAIL beq t=%0d got st=%0d pe=%b op=%b ps=%b want st=8 pe=%b op=01 ps=01", t, bus.state, bus.pcEn, bus.aluOp, bus.pcSrc, t == 0);
      end
      tick();
      exp_ret = exp_ret + 1;
    end
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL beq_retired got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  task automatic test_illegal(input logic [5:0] op);
    bus.opcode = op; bus.memReady = 1'b1;
    tick();
    #1;
    checks++; if (bus.state !== 4'd1 || bus.illegalOp !== 1'b1) begin errors++; $display("FAIL illegal_pulse op=%b got st=%0d ill=%b want st=1 ill=1", op, bus.state, bus.illegalOp); end
    tick();
    checks++;
    if (bus.state !== 4'd0 || bus.illegalOp !== 1'b0 || bus.retired !== exp_ret) begin
      errors++; $display("FAIL illegal_after op=%b got st=%0d ill=%b ret=%0d want st=0 ill=0 ret=%0d", op, bus.state, bus.illegalOp, bus.retired, exp_ret);
    end
  endtask

  task automatic test_reset_midstall();
    logic [15:0] stall_word;
    bus.opcode = OP_LW; bus.memReady = 1'b1;
    tick(); tick(); tick();
    bus.memReady = 1'b0;
    #1;
    stall_word = obs();
    checks++; if (bus.state !== 4'd3 || bus.memRead !== 1'b1 || bus.iorD !== 1'b1) begin errors++; $display("FAIL memrd_stall got st=%0d mr=%b iord=%b want st=3 1 1", bus.state, bus.memRead, bus.iorD); end
    tick();
    #1;
    checks++; if (bus.state !== 4'd3 || obs() !== stall_word) begin errors++; $display("FAIL memrd_stable got st=%0d word=%h want st=3 word=%h", bus.state, obs(), stall_word); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (obs() !== 16'h0000 || bus.state !== 4'd0 || bus.retired !== '0) begin errors++; $display("FAIL midstall_reset got word=%h st=%0d ret=%0d want 0000 0 0", obs(), bus.state, bus.retired); end
    exp_ret = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
`ifdef MIPS_CTRL_ADDI_EN
    bus.opcode = OP_ADDI; bus.memReady = 1'b1;
    tick(); tick();
    #1;
    checks++; if (bus.state !== 4'd10 || bus.aluSrcA !== 1'b1 || bus.aluSrcB !== 2'b10) begin errors++; $display("FAIL addi_exec got st=%0d want 10", bus.state); end
    tick();
    checks++; if (bus.state !== 4'd11 || bus.regWrite !== 1'b1 || bus.regDst !== 1'b0) begin errors++; $display("FAIL addi_wb got st=%0d rw=%b want 11 1", bus.state, bus.regWrite); end
    tick();
    exp_ret = exp_ret + 1;
    checks++; if (bus.retired !== exp_ret) begin errors++; $display("FAIL addi_retired got=%0d want=%0d", bus.retired, exp_ret); end
`else
    test_illegal(OP_ADDI);
`endif
  endtask

  task automatic test_random_program(input int n_instr);
    logic [5:0]  ops [7];
    logic [5:0]  op;
    logic [15:0] exp;
    int          waits;
    int          s;
    int          r;
    bit          wait_st;
    bit          rdy;
    bit          z;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111};
    for (int k = 0; k < n_instr; k++) begin
      r  = $urandom_range(0, 7);
      op = (r < 7) ? ops[r] : 6'($urandom_range(0, 63));
      plan(op);
      bus.opcode = op;
      checks++;
      if (bus.retired !== exp_ret) begin errors++; $display("FAIL rand_retired instr=%0d got=%0d want=%0d", k, bus.retired, exp_ret); end
      foreach (exp_path[i]) begin
        s       = exp_path[i];
        wait_st = (s == 0) || (s == 3) || (s == 5);
        waits   = wait_st ? $urandom_range(0, 3) : 0;
        for (int w = 0; w <= waits; w++) begin
          rdy = wait_st ? (w == waits) : 1'($urandom_range(0, 1));
          z   = 1'($urandom_range(0, 1));
          bus.memReady = rdy;
          bus.zero     = z;
          #1;
          exp = tbl[s];
          if (s == 0 && rdy) begin exp[B_IRW] = 1'b1; exp[B_PCEN] = 1'b1; end
          if (s == 8) exp[B_PCEN] = z;
          if (s == 1 && !plan_retire) exp[B_ILL] = 1'b1;
          checks++;
          if (bus.state !== 4'(s) || obs() !== exp) begin
            errors++;
            $display("FAIL rand_step instr=%0d op=%b got st=%0d word=%h want st=%0d word=%h", k, op, bus.state, obs(), s, exp);
          end
          tick();
        end
      end
      if (plan_retire) exp_ret = exp_ret + 1;
    end
    checks++;
    if (bus.retired !== exp_ret) begin errors++; $display("FAIL rand_final_retired got=%0d want=%0d", bus.retired, exp_ret); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;
    tbl[0]  = 16'b00_0_01_00_0_0_1_0_0_0_0_0_0;
    tbl[1]  = 16'b00_0_11_00_0_0_0_0_0_0_0_0_0;
    tbl[2]  = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    tbl[3]  = 16'b00_0_00_00_0_1_1_0_0_0_0_0_0;
    tbl[4]  = 16'b00_0_00_00_0_0_0_0_0_0_1_1_0;
    tbl[5]  = 16'b00_0_00_00_0_1_0_1_0_0_0_0_0;
    tbl[6]  = 16'b10_1_00_00_0_0_0_0_0_0_0_0_0;
    tbl[7]  = 16'b00_0_00_00_0_0_0_0_0_1_0_1_0;
    tbl[8]  = 16'b01_1_00_01_0_0_0_0_0_0_0_0_0;
    tbl[9]  = 16'b00_0_00_10_1_0_0_0_0_0_0_0_0;
    tbl[10] = 16'b00_1_10_00_0_0_0_0_0_0_0_0_0;
    tbl[11] = 16'b00_0_00_00_0_0_0_0_0_0_0_1_0;
    test_reset();
    test_fetch_stall();
    test_lw();
    test_rtype();
    test_beq();
    test_illegal(6'b111111);
    test_reset_midstall();
    test_addi();
    test_random_program(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
